pc_sequencer: RTL and testbench

- Next-PC controller that sits in front of the PC register and drives its npc input every cycle.
- Chooses between sequential fetch, branch/jump redirect, exception entry and eret return, and applies stall by re-presenting the current pc.
- Buffers a branch/jump redirect that arrives during a stall and replays it when the stall ends.
- Tracks the exception-level flag (exl) so nested exceptions are masked until eret.

---
 rtl/pc_sequencer_pkg.sv | 23 ++
 rtl/pc_redirect_buf.sv | 45 ++++
 rtl/pc_sequencer.sv | 97 +++++++++
 tb/tb_pc_sequencer.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared next-PC definitions: reset/exception addresses, redirect-buffer states
// and the npc source-select code also consumed by the hazard/debug trace.
package pc_sequencer_pkg;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_4180;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    SEL_RESET = 3'd0,
    SEL_EXC   = 3'd1,
    SEL_ERET  = 3'd2,
    SEL_STALL = 3'd3,
    SEL_PEND  = 3'd4,
    SEL_REDIR = 3'd5,
    SEL_SEQ   = 3'd6
  } npc_sel_e;

endpackage

// File: rtl/pc_redirect_buf.sv
// Holds one branch/jump target that arrived while fetch was stalled.
// load wins over consume, so a redirect landing on the replay cycle stays buffered.
module pc_redirect_buf
  import pc_sequencer_pkg::*;
(
  input  logic        clk_i,
  input  logic        clr_i,
  input  logic        load_i,
  input  logic [31:0] load_tgt_i,
  input  logic        consume_i,
  input  logic        clear_i,
  output logic        valid_o,
  output logic [31:0] target_o
);

  state_e      state_q, state_d;
  logic [31:0] tgt_q, tgt_d;

  always_ff @(posedge clk_i) begin
    if (!clr_i) begin
      state_q <= ST_RUN;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    if (clear_i) begin
      state_d = ST_RUN;
    end else if (load_i) begin
      state_d = ST_PEND;
      tgt_d   = load_tgt_i;
    end else if (consume_i) begin
      state_d = ST_RUN;
    end
  end

  assign valid_o  = (state_q == ST_PEND);
  assign target_o = tgt_q;

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC selection in front of the PC register: exception, eret, stall hold,
// buffered-redirect replay, branch/jump redirect, then sequential fetch.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        br_take,
  input  logic [31:0] br_target,
  input  logic        j_take,
  input  logic [31:0] j_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] npc,
  output logic        if_flush,
  output logic        exl,
  output logic        pending
);

  logic        exl_q, exl_d;
  logic        redir;
  logic [31:0] redir_tgt;
  logic        buf_load, buf_consume, buf_clear;
  logic [31:0] pend_tgt;
  npc_sel_e    sel;

  assign redir     = br_take | j_take;
  assign redir_tgt = br_take ? br_target : j_target;

  pc_redirect_buf u_buf (
    .clk_i      (clk),
    .clr_i      (clr),
    .load_i     (buf_load),
    .load_tgt_i (redir_tgt),
    .consume_i  (buf_consume),
    .clear_i    (buf_clear),
    .valid_o    (pending),
    .target_o   (pend_tgt)
  );

  always_ff @(posedge clk) begin
    if (!clr) exl_q <= 1'b0;
    else      exl_q <= exl_d;
  end

  always_comb begin
    sel         = SEL_SEQ;
    exl_d       = exl_q;
    buf_load    = 1'b0;
    buf_consume = 1'b0;
    buf_clear   = 1'b0;
    if (!clr) begin
      sel = SEL_RESET;
    end else if (exc_req && !exl_q) begin
      sel       = SEL_EXC;
      exl_d     = 1'b1;
      buf_clear = 1'b1;
    end else if (eret_req) begin
      sel       = SEL_ERET;
      exl_d     = 1'b0;
      buf_clear = 1'b1;
    end else if (stall) begin
      sel      = SEL_STALL;
      buf_load = redir;
    end else if (pending) begin
      // Replay the buffered target; a fresh redirect this cycle becomes the next one.
      sel         = SEL_PEND;
      buf_load    = redir;
      buf_consume = ~redir;
    end else if (redir) begin
      sel = SEL_REDIR;
    end
  end

  always_comb begin
    npc      = pc + 32'd4;
    if_flush = 1'b0;
    case (sel)
      SEL_RESET: npc = RESET_PC;
      SEL_EXC:   begin npc = EXC_VECTOR; if_flush = 1'b1; end
      SEL_ERET:  begin npc = epc;        if_flush = 1'b1; end
      SEL_STALL: npc = pc;
      SEL_PEND:  npc = pend_tgt;
      SEL_REDIR: npc = redir_tgt;
      default:   npc = pc + 32'd4;
    endcase
  end

  assign exl = exl_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer: stimulus pushes hand-computed
// expectations each cycle, a negedge monitor pops and compares them.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] pc;
  logic        stall, br_take, j_take, exc_req, eret_req;
  logic [31:0] br_target, j_target, epc;
  logic [31:0] npc;
  logic        if_flush, exl, pending;

  typedef struct {
    string       name;
    logic [31:0] npc;
    logic        flush;
    logic        exl;
    logic        pend;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_PC(32'h0000_3000), .EXC_VECTOR(32'h0000_4180)) dut (
    .clk       (clk),
    .clr       (clr),
    .pc        (pc),
    .stall     (stall),
    .br_take   (br_take),
    .br_target (br_target),
    .j_take    (j_take),
    .j_target  (j_target),
    .exc_req   (exc_req),
    .eret_req  (eret_req),
    .epc       (epc),
    .npc       (npc),
    .if_flush  (if_flush),
    .exl       (exl),
    .pending   (pending)
  );

  task automatic idle(input logic [31:0] p);
    clr = 1'b1; pc = p; stall = 1'b0;
    br_take = 1'b0; br_target = '0; j_take = 1'b0; j_target = '0;
    exc_req = 1'b0; eret_req = 1'b0; epc = '0;
  endtask

  // Expected values for the current cycle; exl/pend are the registered values now visible.
  task automatic expect_tick(input string nm, input logic [31:0] e_npc,
                             input logic e_fl, input logic e_exl, input logic e_pd);
    exp_t e;
    e.name = nm; e.npc = e_npc; e.flush = e_fl; e.exl = e_exl; e.pend = e_pd;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (npc !== e.npc) begin
          n_bad++;
          $display("FAIL %s npc: got %h expected %h", e.name, npc, e.npc);
        end
        n_cmp++;
        if (if_flush !== e.flush) begin
          n_bad++;
          $display("FAIL %s if_flush: got %b expected %b", e.name, if_flush, e.flush);
        end
        n_cmp++;
        if (exl !== e.exl) begin
          n_bad++;
          $display("FAIL %s exl: got %b expected %b", e.name, exl, e.exl);
        end
        n_cmp++;
        if (pending !== e.pend) begin
          n_bad++;
          $display("FAIL %s pending: got %b expected %b", e.name, pending, e.pend);
        end
      end
    end
  end

  initial begin : stimulus
    int budget;
    idle(32'h3010); clr = 1'b0;
    @(posedge clk); #1;

    idle(32'h3010); clr = 1'b0;   expect_tick("rst1", 32'h3000, 0, 0, 0);
    idle(32'h3010); clr = 1'b0;   expect_tick("rst2", 32'h3000, 0, 0, 0);
    idle(32'h3010);               expect_tick("rst_rel", 32'h3014, 0, 0, 0);

    idle(32'h3000);               expect_tick("seq", 32'h3004, 0, 0, 0);
    idle(32'h3004); br_take = 1; br_target = 32'h3040;
                                  expect_tick("branch", 32'h3040, 0, 0, 0);

    idle(32'h3008); stall = 1; j_take = 1; j_target = 32'h3100;
                                  expect_tick("stall_j", 32'h3008, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      idle(32'h3008); stall = 1;  expect_tick("stall_hold", 32'h3008, 0, 0, 1);
    end
    idle(32'h3008);               expect_tick("replay", 32'h3100, 0, 0, 1);
    idle(32'h3100);               expect_tick("after_replay", 32'h3104, 0, 0, 0);

    idle(32'h3104); stall = 1; br_take = 1; br_target = 32'h3200;
                                  expect_tick("ow_br", 32'h3104, 0, 0, 0);
    idle(32'h3104); stall = 1; j_take = 1; j_target = 32'h3300;
                                  expect_tick("ow_j", 32'h3104, 0, 0, 1);
    idle(32'h3104);               expect_tick("ow_replay", 32'h3300, 0, 0, 1);
    idle(32'h3300);               expect_tick("ow_after", 32'h3304, 0, 0, 0);

    idle(32'h3304); stall = 1; br_take = 1; br_target = 32'h3500;
                                  expect_tick("pr_load", 32'h3304, 0, 0, 0);
    idle(32'h3304); j_take = 1; j_target = 32'h3600;
                                  expect_tick("pr_replay_relatch", 32'h3500, 0, 0, 1);
    idle(32'h3500);               expect_tick("pr_replay2", 32'h3600, 0, 0, 1);
    idle(32'h3600);               expect_tick("pr_after", 32'h3604, 0, 0, 0);

    idle(32'h3604); stall = 1; j_take = 1; j_target = 32'h3400;
                                  expect_tick("ex_pend", 32'h3604, 0, 0, 0);
    idle(32'h3604); stall = 1; exc_req = 1;
                                  expect_tick("exc_over_stall", 32'h4180, 1, 0, 1);
    idle(32'h4180); exc_req = 1;  expect_tick("exc_masked", 32'h4184, 0, 1, 0);

    idle(32'h4184); eret_req = 1; epc = 32'h3024;
                                  expect_tick("eret", 32'h3024, 1, 1, 0);
    idle(32'h3024); exc_req = 1; eret_req = 1; epc = 32'h3050;
                                  expect_tick("exc_beats_eret", 32'h4180, 1, 0, 0);
    idle(32'h4180); exc_req = 1; eret_req = 1; epc = 32'h3050;
                                  expect_tick("eret_beats_masked", 32'h3050, 1, 1, 0);
    idle(32'h3050);               expect_tick("post_eret", 32'h3054, 0, 0, 0);

    idle(32'hFFFF_FFFC);          expect_tick("wrap", 32'h0000_0000, 0, 0, 0);
    idle(32'h0); br_take = 1; br_target = 32'h3700; j_take = 1; j_target = 32'h3800;
                                  expect_tick("br_wins", 32'h3700, 0, 0, 0);

    idle(32'h3000); exc_req = 1;  expect_tick("mid_exc", 32'h4180, 1, 0, 0);
    idle(32'h4180); stall = 1; j_take = 1; j_target = 32'h3900;
                                  expect_tick("mid_pend", 32'h4180, 0, 1, 0);
    idle(32'h4180); clr = 1'b0;   expect_tick("mid_rst", 32'h3000, 0, 1, 1);
    idle(32'h3000);               expect_tick("mid_rst_rel", 32'h3004, 0, 0, 0);

    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
